uart_msg_dec_fmt: RTL and testbench
===================================

# uart_msg_dec_fmt

Formats a binary value into a fixed-layout ASCII text message and hands it to `uart_tx_msg`. It sits directly upstream of that block. It latches a value on `start` and converts it to decimal with an iterative double-dabble. It builds `PREFIX + digits + SUFFIX`, then drives `uart_tx_msg`'s `msg`/`send` inputs, using its `busy` output to hold the message stable until transmission completes.

## Interface
Parameters:
- `VAL_W`, 16: width of the binary input value.
- `DIGITS`, 5: decimal digit count. Must satisfy 10^DIGITS > 2^VAL_W − 1.
- `PREFIX`, "Time: ": leading text, packed big-endian (first character in the top byte).
- `PREFIX_LEN`, 6: byte count of `PREFIX`.
- `SUFFIX`, "\r\n": trailing text, packed big-endian.
- `SUFFIX_LEN`, 2: byte count of `SUFFIX`.
- `MSG_LEN` (localparam): PREFIX_LEN + DIGITS + SUFFIX_LEN, which is 13 with the defaults. The downstream `uart_tx_msg` `MSG_LEN` must equal this value.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request to format and send `value`. Sampled only in IDLE.
- `value`  in  VAL_W: unsigned binary value, latched on the accepted `start`.
- `tx_busy`  in  1: the `busy` output of `uart_tx_msg`.
- `msg`  out  8*MSG_LEN: formatted message, first-transmitted byte in bits [8*MSG_LEN-1 -: 8]. Drives `uart_tx_msg.msg`.
- `send`  out  1: one-cycle registered pulse. Drives `uart_tx_msg.send`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- The FSM has five states: IDLE, CONV, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - On `start`=1, latch `value` into the shift register, clear the BCD register, set the iteration counter to 0, and go to CONV.
- CONV, one double-dabble iteration per cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {bcd, bin} left by 1.
  - After iteration VAL_W−1, register `msg` from the final BCD and go to SEND.
- Digit rendering:
  - Each digit is 8'h30 + nibble.
  - Leading zeros are replaced by 8'h20 (right-justified).
  - The least significant digit is always rendered, so 0 gives "    0".
- SEND:
  - If `tx_busy`=0, set `send`=1 for the next cycle and go to WAIT_BUSY.
  - Otherwise stay in SEND.
- WAIT_BUSY:
  - On `tx_busy`=1, go to WAIT_DONE.
  - If `tx_busy` has not risen within 4 cycles of the `send` pulse, go to IDLE (anti-hang timeout; 3-bit counter).
- WAIT_DONE:
  - On `tx_busy`=0, go to IDLE.
- `msg` holds constant from entry into SEND until the next conversion completes. It never changes while `uart_tx_msg` is transmitting.
- `start` outside IDLE is ignored; it is not queued.

## Timing
- Reset values: state=IDLE, `send`=0, `busy`=0, `msg`=0, internal counters 0.
- `rst` mid-operation aborts immediately, on the same edge, to these reset values. No `send` pulse follows.
- Edge numbering:
  - `start` is accepted at edge N.
  - CONV iterations occur at edges N+1 … N+VAL_W.
  - `msg` is valid and state=SEND after edge N+VAL_W.
- With `tx_busy`=0, `send` is high for exactly one cycle, between edges N+VAL_W+1 and N+VAL_W+2.
- Conversion latency is exactly VAL_W+1 cycles from `start` to the `send` rise. `tx_busy` only delays it further.
- `busy` rises at edge N and falls on the edge that enters IDLE.
- The earliest following `start` is accepted one cycle after `tx_busy` falls.
- Arithmetic:
  - The BCD register is 4*DIGITS bits; the nibble add is 4-bit with no carry-out.
  - The iteration counter is ⌈log2(VAL_W+1)⌉ bits.

## Test plan
- `value`=456, `start` pulse, `tx_busy` model goes busy 1 cycle after `send` for 200 cycles → `msg`="Time:   456\r\n", one `send` pulse 17 cycles after `start`, `busy` low after `tx_busy` falls.
- `value`=0 → digits "    0". `value`=65535 → digits "65535". `value`=10 → "   10".
- `start` re-asserted every cycle during CONV/WAIT_DONE → exactly one `send` per accepted `start`, and `msg` is unchanged while `tx_busy`=1.
- `tx_busy` held 1 when SEND is reached → `send` stays 0 until `tx_busy` drops, then pulses once.
- `tx_busy` never rises after `send` → return to IDLE 4 cycles after the pulse, `busy`=0.
- `rst` asserted mid-CONV and in WAIT_DONE → next cycle state=IDLE, `send`=0, `busy`=0, `msg`=0. A fresh `start` then converts correctly.

Source files
------------

// File: rtl/uart_msg_dec_fmt.sv
// Converts a binary value to right-justified decimal text and hands a
// PREFIX + digits + SUFFIX message to uart_tx_msg.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start; msg keeps the last formatted text
// CONV      | one double-dabble iteration per cycle, VAL_W cycles
// SEND      | msg valid; waiting for tx_busy low to pulse send
// WAIT_BUSY | send issued; waiting for tx_busy to rise (timeout 4)
// WAIT_DONE | transmitter busy; waiting for tx_busy to fall
module uart_msg_dec_fmt #(
   parameter int VAL_W      = 16,
   parameter int DIGITS     = 5,
   parameter     PREFIX     = "Time: ",
   parameter int PREFIX_LEN = 6,
   parameter     SUFFIX     = "\r\n",
   parameter int SUFFIX_LEN = 2,
   localparam int MSG_LEN   = PREFIX_LEN + DIGITS + SUFFIX_LEN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [VAL_W-1:0]     value,
   input  logic                 tx_busy,
   output logic [8*MSG_LEN-1:0] msg,
   output logic                 send,
   output logic                 busy
);

   localparam int CNT_W = $clog2(VAL_W + 1);
   localparam logic [8*PREFIX_LEN-1:0] PREFIX_B = PREFIX;
   localparam logic [8*SUFFIX_LEN-1:0] SUFFIX_B = SUFFIX;
   localparam logic [CNT_W-1:0]        LAST_ITER = CNT_W'(VAL_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      SEND,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t              state;
   logic [VAL_W-1:0]    bin;
   logic [4*DIGITS-1:0] bcd;
   logic [4*DIGITS-1:0] bcd_adj;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic [CNT_W-1:0]    iter;
   logic [2:0]          tmr;
   logic [8*DIGITS-1:0] digits_txt;
   logic                lead;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      bcd_nxt = {bcd_adj[4*DIGITS-2:0], bin[VAL_W-1]};
   end

   // Rendered from bcd_nxt so the last iteration and the msg load share an edge.
   always_comb begin
      digits_txt = '0;
      lead       = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (lead && (bcd_nxt[4*i +: 4] == 4'd0) && (i != 0)) begin
            digits_txt[8*i +: 8] = 8'h20;
         end else begin
            digits_txt[8*i +: 8] = 8'h30 + {4'h0, bcd_nxt[4*i +: 4]};
            lead = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bin   <= '0;
         bcd   <= '0;
         iter  <= '0;
         tmr   <= '0;
         msg   <= '0;
         send  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         send <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin   <= value;
                  bcd   <= '0;
                  iter  <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               bin  <= bin << 1;
               bcd  <= bcd_nxt;
               iter <= iter + 1'b1;
               if (iter == LAST_ITER) begin
                  msg   <= {PREFIX_B, digits_txt, SUFFIX_B};
                  state <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  send  <= 1'b1;
                  tmr   <= 3'd3;
                  state <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               // Down-counter guards against a transmitter that never answers.
               if (tx_busy) begin
                  tmr   <= '0;
                  state <= WAIT_DONE;
               end else if (tmr == 3'd0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  tmr <= tmr - 3'd1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_msg_dec_fmt.sv
// Bench for uart_msg_dec_fmt: vector table through a scoreboard that is
// popped on every send pulse, plus hand-written corner sequences.
module tb_uart_msg_dec_fmt;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [15:0]  value = '0;
   logic         tx_busy;
   logic [103:0] msg;
   logic         send;
   logic         busy;

   logic         tx_force = 1'b0;
   logic         model_en = 1'b1;
   logic         tx_busy_m;
   int           busy_len = 20;
   int           bcnt;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           n_send = 0;
   logic [103:0] last_msg = '0;
   bit           have_last = 1'b0;

   typedef struct {
      logic [103:0] m;
      int           lat;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [15:0] v;
      logic [39:0] digs;
      int          blen;
   } vec_t;
   vec_t tbl[9];

   always #5 clk = ~clk;
   assign tx_busy = tx_force | tx_busy_m;

   uart_msg_dec_fmt dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .value   (value),
      .tx_busy (tx_busy),
      .msg     (msg),
      .send    (send),
      .busy    (busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: goes busy the cycle after send, for busy_len cycles.
   always @(posedge clk) begin
      if (rst) begin
         tx_busy_m <= 1'b0;
         bcnt      <= 0;
      end else if (model_en && send && !tx_busy_m) begin
         tx_busy_m <= 1'b1;
         bcnt      <= busy_len - 1;
      end else if (tx_busy_m) begin
         if (bcnt == 0) tx_busy_m <= 1'b0;
         else           bcnt <= bcnt - 1;
      end
   end

   always @(negedge clk) begin
      if (send) begin
         exp_t e;
         n_send++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_send: got send with msg %h, required no send", msg);
         end else begin
            e = sb.pop_front();
            if (msg !== e.m) begin
               errors++;
               $display("FAIL send_msg: got \"%s\" required \"%s\"", msg, e.m);
            end
            if (e.lat >= 0) begin
               checks++;
               if (cyc != e.lat) begin
                  errors++;
                  $display("FAIL send_latency: got cycle %0d required %0d", cyc, e.lat);
               end
            end
         end
         last_msg  = msg;
         have_last = 1'b1;
      end
      if (tx_busy_m && have_last) begin
         checks++;
         if (msg !== last_msg) begin
            errors++;
            $display("FAIL msg_stable: got %h required %h", msg, last_msg);
         end
      end
   end

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic chkm(input string name, input logic [103:0] act, input logic [103:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [103:0] mk(input logic [39:0] d);
      return {"Time: ", d, "\r\n"};
   endfunction

   task automatic do_start(input logic [15:0] v, input logic [39:0] d, input bit lat_chk);
      exp_t e;
      @(negedge clk);
      e.m   = mk(d);
      e.lat = lat_chk ? cyc + 18 : -1;
      sb.push_back(e);
      value = v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max);
      int k = 0;
      while (busy && k < max) begin
         @(negedge clk);
         k++;
      end
      chkb(name, busy, 1'b0);
   endtask

   initial begin
      int  s0;
      int  k;
      int  t0;
      bit  seen;

      tbl[0] = '{16'd456,   "  456", 200};
      tbl[1] = '{16'd0,     "    0", 5};
      tbl[2] = '{16'd65535, "65535", 6};
      tbl[3] = '{16'd10,    "   10", 3};
      tbl[4] = '{16'd1,     "    1", 4};
      tbl[5] = '{16'd9,     "    9", 8};
      tbl[6] = '{16'd1000,  " 1000", 5};
      tbl[7] = '{16'd40960, "40960", 7};
      tbl[8] = '{16'd10009, "10009", 2};

      repeat (3) @(negedge clk);
      chkb("reset_busy", busy, 1'b0);
      chkb("reset_send", send, 1'b0);
      chkm("reset_msg", msg, '0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         busy_len = tbl[i].blen;
         do_start(tbl[i].v, tbl[i].digs, 1'b1);
         wait_idle($sformatf("tbl%0d_idle", i), 400);
         chkm($sformatf("tbl%0d_msg_after", i), msg, mk(tbl[i].digs));
      end

      // start held through the whole transaction; value changes after accept
      busy_len = 30;
      s0 = n_send;
      begin
         exp_t e;
         @(negedge clk);
         e.m   = mk(" 1234");
         e.lat = cyc + 18;
         sb.push_back(e);
         value = 16'd1234;
         start = 1'b1;
      end
      seen = 1'b0;
      k    = 0;
      do begin
         @(negedge clk);
         value = 16'd4321;
         if (tx_busy_m) seen = 1'b1;
         k++;
      end while (!(seen && !tx_busy_m) && k < 300);
      start = 1'b0;
      chkb("held_start_tx_seen", seen, 1'b1);
      wait_idle("held_start_idle", 50);
      repeat (5) @(negedge clk);
      chki("held_start_send_count", n_send - s0, 1);
      chkm("held_start_msg", msg, mk(" 1234"));

      // tx_busy already high when SEND is reached
      busy_len = 10;
      tx_force = 1'b1;
      s0 = n_send;
      do_start(16'd2024, " 2024", 1'b0);
      repeat (30) @(negedge clk);
      chki("hold_no_send", n_send - s0, 0);
      chkb("hold_busy", busy, 1'b1);
      tx_force = 1'b0;
      wait_idle("hold_idle", 100);
      chki("hold_one_send", n_send - s0, 1);

      // transmitter never answers: timeout four cycles after the pulse
      model_en = 1'b0;
      do_start(16'd7, "    7", 1'b1);
      k = 0;
      while (!send && k < 50) begin
         @(negedge clk);
         k++;
      end
      chkb("timeout_send_seen", send, 1'b1);
      t0 = cyc;
      wait_idle("timeout_idle", 20);
      chki("timeout_cycles", cyc - t0, 4);
      model_en = 1'b1;

      // reset during CONV
      do_start(16'd999, "  999", 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chkb("rst_conv_busy", busy, 1'b0);
      chkb("rst_conv_send", send, 1'b0);
      chkm("rst_conv_msg", msg, '0);
      rst = 1'b0;
      sb.delete();
      s0 = n_send;
      repeat (30) @(negedge clk);
      chki("rst_conv_no_send", n_send - s0, 0);

      // reset during WAIT_DONE, then a fresh conversion
      busy_len = 50;
      do_start(16'd555, "  555", 1'b0);
      k = 0;
      while (!tx_busy_m && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      chkb("wait_done_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chkb("rst_wd_busy", busy, 1'b0);
      chkb("rst_wd_send", send, 1'b0);
      chkm("rst_wd_msg", msg, '0);
      rst = 1'b0;
      busy_len = 5;
      do_start(16'd31415, "31415", 1'b1);
      wait_idle("post_rst_idle", 100);
      chkm("post_rst_msg", msg, mk("31415"));

      chki("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
